// File: rtl/imm_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : imm_branch_sequencer
// Description : LEGv8 immediate decode/extend plus PC-relative branch target,
//               two-stage valid/ready pipeline with flush and branch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_branch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [63:0]      pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       fmt,
    output logic             is_branch,
    output logic [63:0]      imm,
    output logic [63:0]      br_target,
    output logic [63:0]      out_pc,
    output logic [CNT_W-1:0] branch_cnt
);

    localparam logic [2:0]       c_FMT_NONE = 3'd0;
    localparam logic [2:0]       c_FMT_B26  = 3'd1;
    localparam logic [2:0]       c_FMT_B19  = 3'd2;
    localparam logic [2:0]       c_FMT_D9   = 3'd3;
    localparam logic [2:0]       c_FMT_I12  = 3'd4;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [2:0]       w_fmt;
    logic [63:0]      w_imm;
    logic             w_s1_ready;
    logic             w_s2_ready;
    logic             w_s1_is_br;
    logic [63:0]      w_s1_target;

    logic             r_s1_valid;
    logic [2:0]       r_s1_fmt;
    logic [63:0]      r_s1_imm;
    logic [63:0]      r_s1_pc;
    logic             r_s2_valid;
    logic [2:0]       r_s2_fmt;
    logic [63:0]      r_s2_imm;
    logic [63:0]      r_s2_pc;
    logic [63:0]      r_s2_target;
    logic [CNT_W-1:0] r_cnt;

    // Opcode classification; earlier matches win.
    always_comb begin
        w_fmt = c_FMT_NONE;
        w_imm = 64'd0;
        if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
            w_fmt = c_FMT_B26;
            w_imm = {{38{instr[25]}}, instr[25:0]};
        end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101 ||
                     instr[31:24] == 8'b01010100) begin
            w_fmt = c_FMT_B19;
            w_imm = {{45{instr[23]}}, instr[23:5]};
        end else if (instr[31:21] == 11'b11111000000 || instr[31:21] == 11'b11111000010) begin
            w_fmt = c_FMT_D9;
            w_imm = {{55{instr[20]}}, instr[20:12]};
        end else if (instr[31:22] == 10'b1001000100) begin
            w_fmt = c_FMT_I12;
            w_imm = {52'd0, instr[21:10]};
        end
    end

    assign w_s2_ready  = !r_s2_valid || out_ready;
    assign w_s1_ready  = !r_s1_valid || w_s2_ready;
    assign in_ready    = w_s1_ready && !flush && reset_n;

    assign w_s1_is_br  = (r_s1_fmt == c_FMT_B26) || (r_s1_fmt == c_FMT_B19);
    assign w_s1_target = r_s1_pc + (r_s1_imm << 2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_fmt   <= c_FMT_NONE;
            r_s1_imm   <= 64'd0;
            r_s1_pc    <= 64'd0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fmt <= w_fmt;
                r_s1_imm <= w_imm;
                r_s1_pc  <= pc;
            end
        end
    end

    // Stage 2 registers only move when it can hand off, so outputs hold during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_fmt    <= c_FMT_NONE;
            r_s2_imm    <= 64'd0;
            r_s2_pc     <= 64'd0;
            r_s2_target <= 64'd0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_fmt    <= r_s1_fmt;
                r_s2_imm    <= r_s1_imm;
                r_s2_pc     <= r_s1_pc;
                r_s2_target <= w_s1_is_br ? w_s1_target : 64'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_s2_valid && out_ready && is_branch && !flush && r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign fmt        = r_s2_fmt;
    assign is_branch  = (r_s2_fmt == c_FMT_B26) || (r_s2_fmt == c_FMT_B19);
    assign imm        = r_s2_imm;
    assign br_target  = r_s2_target;
    assign out_pc     = r_s2_pc;
    assign branch_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_branch_sequencer
// Description : Directed bench with a queue-based reference model for
//               imm_branch_sequencer (CNT_W=4 so saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_branch_sequencer;

    localparam int CNT_W = 4;
    localparam logic [31:0] c_B_M1  = 32'h17FF_FFFF;
    localparam logic [31:0] c_CBZ   = 32'hB400_0200;
    localparam logic [31:0] c_LDUR  = 32'hF85F_0000;
    localparam logic [31:0] c_ADDI0 = 32'h9100_0000;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      instr = 32'd0;
    logic [63:0]      pc = 64'd0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       fmt;
    logic             is_branch;
    logic [63:0]      imm;
    logic [63:0]      br_target;
    logic [63:0]      out_pc;
    logic [CNT_W-1:0] branch_cnt;

    int total = 0;
    int bad   = 0;

    imm_branch_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .fmt(fmt), .is_branch(is_branch), .imm(imm),
        .br_target(br_target), .out_pc(out_pc), .branch_cnt(branch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  fmt;
        bit          br;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [63:0] pc;
        int          age;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;
    bit   m_ov;
    bit   m_ir;

    function automatic logic [63:0] sx(input logic [63:0] v, input int w);
        logic signed [63:0] s;
        s = v << (64 - w);
        return s >>> (64 - w);
    endfunction

    function automatic ent_t decode(input logic [31:0] w, input logic [63:0] p);
        ent_t e;
        int unsigned op6, op8, op10, op11;
        op6 = w >> 26; op8 = w >> 24; op10 = w >> 22; op11 = w >> 21;
        e.fmt = 3'd0; e.imm = 64'd0; e.pc = p; e.age = 0;
        if (op6 == 5 || op6 == 37) begin
            e.fmt = 3'd1; e.imm = sx(64'(w % (1 << 26)), 26);
        end else if (op8 == 'hB4 || op8 == 'hB5 || op8 == 'h54) begin
            e.fmt = 3'd2; e.imm = sx(64'((w >> 5) % (1 << 19)), 19);
        end else if (op11 == 'h7C0 || op11 == 'h7C2) begin
            e.fmt = 3'd3; e.imm = sx(64'((w >> 12) % 512), 9);
        end else if (op10 == 'h244) begin
            e.fmt = 3'd4; e.imm = 64'((w >> 10) % 4096);
        end
        e.br  = (e.fmt == 3'd1 || e.fmt == 3'd2);
        e.tgt = e.br ? p + e.imm * 4 : 64'd0;
        return e;
    endfunction

    // Occupancy view: head is at the output once it has seen two edges.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_cnt = 0;
        end else begin
            m_ov = q.size() > 0 && q[0].age >= 2;
            m_ir = !flush && (q.size() < 2 || out_ready);
            if (flush) begin
                q.delete();
            end else begin
                if (m_ov && out_ready) begin
                    if (q[0].br && m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    void'(q.pop_front());
                end
                if (in_valid && m_ir) q.push_back(decode(instr, pc));
                foreach (q[i]) q[i].age++;
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = q.size() > 0 && q[0].age >= 2;
        chk("m_in_ready", in_ready, reset_n && !flush && (q.size() < 2 || out_ready));
        chk("m_out_valid", out_valid, ev);
        chk("m_branch_cnt", branch_cnt, m_cnt);
        if (ev) begin
            chk("m_fmt", fmt, q[0].fmt);
            chk("m_is_branch", is_branch, q[0].br);
            chk("m_imm", imm, q[0].imm);
            chk("m_br_target", br_target, q[0].tgt);
            chk("m_out_pc", out_pc, q[0].pc);
        end else if (!reset_n) begin
            chk("m_rst_data", {fmt, is_branch} | imm | br_target | out_pc, 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] ins, input logic [63:0] p);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; instr = ins; pc = p;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) chk("out_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] addi(input int k);
        return c_ADDI0 | (32'(k) << 10);
    endfunction

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cnt", branch_cnt, 0);
        chk("rst_fmt", fmt, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: B with imm26 = -1, two-edge latency
        out_ready = 1'b1;
        send(c_B_M1, 64'h1000);
        @(negedge clk);
        chk("t1_latency_n1", out_valid, 0);
        @(negedge clk);
        chk("t1_latency_n2", out_valid, 1);
        chk("t1_fmt", fmt, 1);
        chk("t1_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_tgt", br_target, 64'hFFC);
        @(negedge clk);
        chk("t1_cnt", branch_cnt, 1);

        // 2: CBZ
        @(posedge clk); #1;
        send(c_CBZ, 64'h2000);
        wait_out();
        chk("t2_fmt", fmt, 2);
        chk("t2_imm", imm, 64'h10);
        chk("t2_tgt", br_target, 64'h2040);
        chk("t2_pc", out_pc, 64'h2000);

        // 3: LDUR, negative imm9
        @(posedge clk); #1;
        send(c_LDUR, 64'h3000);
        wait_out();
        chk("t3_fmt", fmt, 3);
        chk("t3_imm", imm, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("t3_isbr", is_branch, 0);
        chk("t3_tgt", br_target, 0);
        @(negedge clk);
        chk("t3_cnt", branch_cnt, 2);

        // 4: backpressure with four ADDIs
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(addi(1), 64'h4000);
        send(addi(2), 64'h4004);
        in_valid = 1'b1; instr = addi(3); pc = 64'h4008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_ready", in_ready, 0);
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_imm", imm, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            begin
                send(addi(3), 64'h4008);
                send(addi(4), 64'h400C);
            end
            begin
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    chk("t4_order_valid", out_valid, 1);
                    chk("t4_order_imm", imm, 64'(k));
                end
            end
        join

        // 5: flush beats a simultaneous handshake
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(c_B_M1, 64'h5000);
        send(c_CBZ, 64'h5004);
        out_ready = 1'b1; flush = 1'b1;
        in_valid = 1'b1; instr = c_CBZ; pc = 64'h5008;
        @(negedge clk);
        chk("t5_flush_in_ready", in_ready, 0);
        chk("t5_flush_out_valid", out_valid, 1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_after_valid", out_valid, 0);
            chk("t5_after_cnt", branch_cnt, 2);
        end

        // 6: saturation at 15, then asynchronous reset mid-stream
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) send(c_CBZ, 64'(i * 4));
        repeat (4) @(negedge clk);
        chk("t6_sat", branch_cnt, 15);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(c_B_M1, 64'h6000);
        send(addi(7), 64'h6004);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_arst_valid", out_valid, 0);
        chk("t6_arst_cnt", branch_cnt, 0);
        chk("t6_arst_ready", in_ready, 0);
        chk("t6_arst_data", {fmt, is_branch} | imm | br_target | out_pc, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        send(addi(9), 64'h7000);
        wait_out();
        chk("t6_post_imm", imm, 9);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
